// File: rtl/adder_sweep_sequencer_if.sv
// Bundle between the sweep sequencer, its controller and the adder under test.
// master is the sequencer side; slave is the controller/adder side.
interface adder_sweep_sequencer_if;
  logic       start;
  logic       abort;
  logic       stop_on_fail;
  logic [3:0] dut_a;
  logic [3:0] dut_b;
  logic       dut_cin;
  logic [3:0] dut_sum;
  logic       dut_cout;
  logic       busy;
  logic       done;
  logic       pass;
  logic [9:0] err_count;
  logic       first_fail_valid;
  logic [8:0] first_fail_vec;
  logic [4:0] first_fail_got;

  modport master (
    input  start, abort, stop_on_fail, dut_sum, dut_cout,
    output dut_a, dut_b, dut_cin, busy, done, pass, err_count,
           first_fail_valid, first_fail_vec, first_fail_got
  );

  modport slave (
    output start, abort, stop_on_fail, dut_sum, dut_cout,
    input  dut_a, dut_b, dut_cin, busy, done, pass, err_count,
           first_fail_valid, first_fail_vec, first_fail_got
  );
endinterface

// File: rtl/adder_sweep_sequencer.sv
// Exhaustive 512-vector sweep of an external 4-bit adder with golden compare,
// mismatch count and first-failure capture.
module adder_sweep_sequencer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  adder_sweep_sequencer_if.master  bus_io
);

  typedef enum logic [2:0] {StIdle, StDrive, StWait, StCheck, StDone} state_e;

  localparam logic [3:0] SettleCnt = 4'(SETTLE);

  state_e     state_q, state_d;
  logic [8:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic       stop_q, stop_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic       cin_q, cin_d;
  logic [9:0] err_q, err_d;
  logic       ffv_q, ffv_d;
  logic [8:0] ffvec_q, ffvec_d;
  logic [4:0] ffgot_q, ffgot_d;

  logic [4:0] golden, observed;
  logic       mismatch;

  // Golden uses the registered operands, which equal vec for the whole WAIT/CHECK window.
  assign golden   = 5'(a_q) + 5'(b_q) + 5'(cin_q);
  assign observed = {bus_io.dut_cout, bus_io.dut_sum};
  assign mismatch = (observed != golden);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    ffgot_d = ffgot_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus_io.start) begin
          err_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
          ffgot_d = '0;
          vec_d   = '0;
          stop_d  = bus_io.stop_on_fail;
          state_d = StDrive;
        end
      end
      StDrive: begin
        if (bus_io.abort) begin
          state_d = StIdle;
        end else begin
          a_d     = vec_q[3:0];
          b_d     = vec_q[7:4];
          cin_d   = vec_q[8];
          cnt_d   = SettleCnt;
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus_io.abort) begin
          state_d = StIdle;
        end else if (cnt_q <= 4'd1) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StCheck: begin
        if (bus_io.abort) begin
          state_d = StIdle;
        end else begin
          if (mismatch) begin
            err_d = err_q + 10'd1;
            if (!ffv_q) begin
              ffv_d   = 1'b1;
              ffvec_d = vec_q;
              ffgot_d = observed;
            end
          end
          if (vec_q == 9'd511 || (mismatch && stop_q)) begin
            state_d = StDone;
          end else begin
            vec_d   = vec_q + 9'd1;
            state_d = StDrive;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
      ffgot_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
      ffgot_q <= ffgot_d;
    end
  end

  assign bus_io.dut_a            = a_q;
  assign bus_io.dut_b            = b_q;
  assign bus_io.dut_cin          = cin_q;
  assign bus_io.busy             = (state_q == StDrive) || (state_q == StWait) ||
                                   (state_q == StCheck);
  assign bus_io.done             = (state_q == StDone);
  assign bus_io.pass             = (state_q == StDone) && (err_q == 10'd0);
  assign bus_io.err_count        = err_q;
  assign bus_io.first_fail_valid = ffv_q;
  assign bus_io.first_fail_vec   = ffvec_q;
  assign bus_io.first_fail_got   = ffgot_q;

endmodule
